// File: rtl/jk_ff_bank_scheduler.sv
// Two-requester round-robin command FIFO feeding a one-shot J/K issue FSM for a JK flip-flop bank.
// Optional Q readback check is built when JK_FF_BANK_SCHEDULER_VERIFY_EN is defined.
module jk_ff_bank_scheduler #(
  parameter int NUM_FF     = 8,
  parameter int IDX_W      = $clog2(NUM_FF),
  parameter int FIFO_DEPTH = 4
) (
  input  logic              Clk_In,
  input  logic              Reset_In,
  input  logic              A_Valid_In,
  input  logic [1:0]        A_Op_In,
  input  logic [IDX_W-1:0]  A_Idx_In,
  output logic              A_Ready_Out,
  input  logic              B_Valid_In,
  input  logic [1:0]        B_Op_In,
  input  logic [IDX_W-1:0]  B_Idx_In,
  output logic              B_Ready_Out,
  output logic [NUM_FF-1:0] J_Out,
  output logic [NUM_FF-1:0] K_Out,
  input  logic [NUM_FF-1:0] Q_In,
  output logic              Busy_Out,
  output logic              Done_Out,
  output logic [IDX_W-1:0]  Done_Idx_Out,
  output logic              Error_Out
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int CMD_W = IDX_W + 2;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DONE = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [CMD_W-1:0]  fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              last_grant_b_q, last_grant_b_d;
  logic [NUM_FF-1:0] j_q, j_d, k_q, k_d;
  logic [IDX_W-1:0]  done_idx_q, done_idx_d;
  logic              fifo_full, fifo_empty, push, pop;
  logic [CMD_W-1:0]  push_cmd, head_cmd;
  logic [1:0]        head_op;
  logic [IDX_W-1:0]  head_idx;

  // Both readies depend only on registered state plus the two valids, so grants are exclusive.
  assign fifo_full   = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty  = (count_q == '0);
  assign A_Ready_Out = !fifo_full && A_Valid_In && (!B_Valid_In || last_grant_b_q);
  assign B_Ready_Out = !fifo_full && B_Valid_In && (!A_Valid_In || !last_grant_b_q);
  assign push        = A_Ready_Out || B_Ready_Out;
  assign push_cmd    = A_Ready_Out ? {A_Op_In, A_Idx_In} : {B_Op_In, B_Idx_In};
  assign head_cmd    = fifo_q[rd_ptr_q];
  assign head_op     = head_cmd[CMD_W-1 -: 2];
  assign head_idx    = head_cmd[IDX_W-1:0];

  always_comb begin
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    last_grant_b_d = last_grant_b_q;
    if (push) begin
      wr_ptr_d       = wr_ptr_q + PTR_W'(1);
      last_grant_b_d = B_Ready_Out;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push && pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge Clk_In or negedge Reset_In) begin
    if (!Reset_In) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      last_grant_b_q <= 1'b1;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      last_grant_b_q <= last_grant_b_d;
      if (push) begin
        fifo_q[wr_ptr_q] <= push_cmd;
      end
    end
  end

  always_ff @(posedge Clk_In or negedge Reset_In) begin
    if (!Reset_In) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!fifo_empty) state_d = ISSUE;
      ISSUE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // An out-of-range index shifts the J/K bit off the vector, so it degrades to a hold.
  always_comb begin
    pop        = 1'b0;
    j_d        = '0;
    k_d        = '0;
    done_idx_d = done_idx_q;
    Done_Out   = (state_q == DONE);
    if (state_q == IDLE && !fifo_empty) begin
      pop        = 1'b1;
      j_d        = NUM_FF'(head_op[1]) << head_idx;
      k_d        = NUM_FF'(head_op[0]) << head_idx;
      done_idx_d = head_idx;
    end
  end

  always_ff @(posedge Clk_In or negedge Reset_In) begin
    if (!Reset_In) begin
      j_q        <= '0;
      k_q        <= '0;
      done_idx_q <= '0;
    end else begin
      j_q        <= j_d;
      k_q        <= k_d;
      done_idx_q <= done_idx_d;
    end
  end

  assign J_Out        = j_q;
  assign K_Out        = k_q;
  assign Done_Idx_Out = done_idx_q;
  assign Busy_Out     = (state_q != IDLE) || !fifo_empty;

`ifdef JK_FF_BANK_SCHEDULER_VERIFY_EN
  logic       q_prev_q, q_prev_d;
  logic [1:0] op_q, op_d;
  logic       error_q, error_d;
  logic       expected_val, mismatch;

  always_comb begin
    q_prev_d = q_prev_q;
    op_d     = op_q;
    if (pop) begin
      q_prev_d = Q_In[head_idx];
      op_d     = head_op;
    end
    case (op_q)
      2'b01:   expected_val = 1'b0;
      2'b10:   expected_val = 1'b1;
      2'b11:   expected_val = ~q_prev_q;
      default: expected_val = q_prev_q;
    endcase
    mismatch = (state_q == DONE) && (int'(done_idx_q) < NUM_FF) &&
               (Q_In[done_idx_q] != expected_val);
    error_d  = error_q | mismatch;
  end

  always_ff @(posedge Clk_In or negedge Reset_In) begin
    if (!Reset_In) begin
      q_prev_q <= 1'b0;
      op_q     <= 2'b00;
      error_q  <= 1'b0;
    end else begin
      q_prev_q <= q_prev_d;
      op_q     <= op_d;
      error_q  <= error_d;
    end
  end

  // The flag is raised during DONE itself and then held by the sticky register.
  assign Error_Out = error_q | mismatch;
`else
  logic unused_q_in;
  assign unused_q_in = ^Q_In;
  assign Error_Out   = 1'b0;
`endif

endmodule
